// File: rtl/irq_sequencer.sv
// Multi-source interrupt sequencer: latches, masks and prioritises requests,
// drains the pipeline, then injects an sf1 pseudo-instruction with a vector.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an eligible pending source
// ST_DRAIN  | counting un-stalled cycles before injection
// ST_INJECT | sf1 driven into fetch until the first un-stalled cycle
module irq_sequencer #(
  parameter int NUM_IRQ   = 4,
  parameter int ID_W      = 2,
  parameter int VEC_W     = 8,
  parameter int VEC_BASE  = 0,
  parameter int DRAIN_CYC = 2,
  parameter bit NEST_EN   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic               rti_retire,
  output logic               sf1,
  output logic [VEC_W-1:0]   vec_addr,
  output logic               int_clr,
  output logic               int_en,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_INJECT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYC);

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic [ID_W-1:0]    sel_id, sel_n;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] in_service;
  logic [NUM_IRQ-1:0] eligible;
  logic               blocked;
  logic               any_elig;
  logic [ID_W-1:0]    cand_id;
  logic [NUM_IRQ-1:0] retire_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] pending_n;
  logic [NUM_IRQ-1:0] isv_n;

  // With nesting, blocked accumulates in-service bits at or above each index's priority.
  always_comb begin
    eligible = '0;
    blocked  = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (NEST_EN) blocked = blocked | in_service[k];
      else         blocked = |in_service;
      eligible[k] = pending[k] & mask[k] & ~blocked;
    end
  end

  always_comb begin
    any_elig = |eligible;
    cand_id  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) cand_id = ID_W'(k);
    end
  end

  always_comb begin
    active_id = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (in_service[k]) active_id = ID_W'(k);
    end
  end

  // Lowest set in-service bit isolated as v & -v.
  assign retire_vec = rti_retire ? (in_service & (~in_service + NUM_IRQ'(1))) : '0;
  assign int_en     = |in_service;
  assign vec_addr   = VEC_W'(VEC_BASE) + VEC_W'(sel_id);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_id;
    sf1     = 1'b0;
    int_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_elig) begin
          state_n = ST_DRAIN;
          cnt_n   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        if (branch_taken) begin
          cnt_n = CNT_LOAD;
        end else if (!stall_in) begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (any_elig) begin
              state_n = ST_INJECT;
              sel_n   = cand_id;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      ST_INJECT: begin
        sf1 = 1'b1;
        if (!stall_in) begin
          int_clr = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Retire is applied before the newly accepted source is marked in service.
  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      clr_vec[k] = int_clr && (sel_id == ID_W'(k));
    end
    pending_n = (pending & ~clr_vec) | (irq_in & ~irq_prev);
    isv_n     = (in_service & ~retire_vec) | clr_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel_id     <= '0;
      irq_prev   <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel_id     <= sel_n;
      irq_prev   <= irq_in;
      pending    <= pending_n;
      in_service <= isv_n;
      if (mask_wr) mask <= mask_in;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: a non-nesting and a nesting instance share stimulus
// and are compared every cycle against a behavioural model, plus literal checks.
module tb_irq_sequencer;

  localparam int DRAIN = 2;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_wr;
  logic [3:0] mask_in;
  logic       stall_in;
  logic       branch_taken;
  logic       rti_retire;

  logic [1:0]      sf1_d;
  logic [1:0]      clr_d;
  logic [1:0]      en_d;
  logic [1:0][7:0] vec_d;
  logic [1:0][1:0] aid_d;
  logic [1:0][3:0] pend_d;
  logic [1:0][3:0] mask_d;

  int checks   = 0;
  int failures = 0;

  irq_sequencer #(.NUM_IRQ(4), .ID_W(2), .VEC_W(8), .VEC_BASE(0),
                  .DRAIN_CYC(DRAIN), .NEST_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr), .mask_in(mask_in),
    .stall_in(stall_in), .branch_taken(branch_taken), .rti_retire(rti_retire),
    .sf1(sf1_d[0]), .vec_addr(vec_d[0]), .int_clr(clr_d[0]), .int_en(en_d[0]),
    .active_id(aid_d[0]), .pending(pend_d[0]), .mask(mask_d[0]));

  irq_sequencer #(.NUM_IRQ(4), .ID_W(2), .VEC_W(8), .VEC_BASE(0),
                  .DRAIN_CYC(DRAIN), .NEST_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr), .mask_in(mask_in),
    .stall_in(stall_in), .branch_taken(branch_taken), .rti_retire(rti_retire),
    .sf1(sf1_d[1]), .vec_addr(vec_d[1]), .int_clr(clr_d[1]), .int_en(en_d[1]),
    .active_id(aid_d[1]), .pending(pend_d[1]), .mask(mask_d[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting, 1 = draining (m_left un-stalled cycles still owed), 2 = offering sf1.
  logic [3:0] m_pend [2];
  logic [3:0] m_isv  [2];
  logic [3:0] m_mask [2];
  logic [3:0] m_prev [2];
  int         m_phase[2];
  int         m_left [2];
  int         m_sel  [2];

  function automatic int lowest(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [3:0] model_eligible(input int i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      bit ok;
      if (i == 1) ok = ((m_isv[i] & 4'((2 << k) - 1)) == 4'd0);
      else        ok = (m_isv[i] == 4'd0);
      r[k] = m_pend[i][k] & m_mask[i][k] & ok;
    end
    return r;
  endfunction

  task automatic model_step(input int i);
    int c;
    bit acc;
    logic [3:0] np, ni;
    if (!rst) begin
      m_pend[i] = '0; m_isv[i] = '0; m_mask[i] = 4'hf; m_prev[i] = '0;
      m_phase[i] = 0; m_left[i] = 0; m_sel[i] = 0;
      return;
    end
    c   = lowest(model_eligible(i));
    acc = (m_phase[i] == 2) && !stall_in;
    np  = m_pend[i];
    ni  = m_isv[i];
    if (rti_retire && ni != 4'd0) ni[lowest(ni)] = 1'b0;
    if (acc) begin
      np[m_sel[i]] = 1'b0;
      ni[m_sel[i]] = 1'b1;
    end
    np = np | (irq_in & ~m_prev[i]);
    case (m_phase[i])
      0: if (c >= 0) begin m_phase[i] = 1; m_left[i] = DRAIN; end
      1: begin
        if (branch_taken) m_left[i] = DRAIN;
        else if (!stall_in) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            if (c >= 0) begin m_phase[i] = 2; m_sel[i] = c; end
            else m_phase[i] = 0;
          end
        end
      end
      default: if (acc) m_phase[i] = 0;
    endcase
    m_pend[i] = np;
    m_isv[i]  = ni;
    m_prev[i] = irq_in;
    if (mask_wr) m_mask[i] = mask_in;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = '0; m_isv[i] = '0; m_mask[i] = 4'hf; m_prev[i] = '0;
      m_phase[i] = 0; m_left[i] = 0; m_sel[i] = 0;
    end
  end

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit         e_sf1, e_clr, e_en;
      int         e_aid;
      logic [3:0] e_p, e_m;
      if (!rst) begin
        e_sf1 = 0; e_clr = 0; e_en = 0; e_aid = 0; e_p = '0; e_m = 4'hf;
      end else begin
        e_sf1 = (m_phase[i] == 2);
        e_clr = e_sf1 && !stall_in;
        e_en  = (m_isv[i] != 4'd0);
        e_aid = e_en ? lowest(m_isv[i]) : 0;
        e_p   = m_pend[i];
        e_m   = m_mask[i];
      end
      chk($sformatf("m%0d_sf1", i), sf1_d[i], e_sf1);
      chk($sformatf("m%0d_int_clr", i), clr_d[i], e_clr);
      chk($sformatf("m%0d_int_en", i), en_d[i], e_en);
      chk($sformatf("m%0d_active_id", i), aid_d[i], e_aid);
      chk($sformatf("m%0d_pending", i), pend_d[i], e_p);
      chk($sformatf("m%0d_mask", i), mask_d[i], e_m);
      if (e_sf1) chk($sformatf("m%0d_vec_addr", i), vec_d[i], (!rst) ? 0 : m_sel[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_rti();
    rti_retire = 1'b1;
    tick();
    rti_retire = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_in = '0;
    stall_in = 1'b0; branch_taken = 1'b0; rti_retire = 1'b0;
    ticks(2);
    rst = 1'b1;
    #1;
    chk("rst_sf1", sf1_d[0], 0);
    chk("rst_pending", pend_d[0], 0);
    chk("rst_mask", mask_d[0], 4'hf);
    chk("rst_int_en", en_d[0], 0);
    chk("rst_active_id", aid_d[0], 0);
    chk("rst_vec_addr", vec_d[0], 0);

    // Single source, no stalls: sf1 four cycles after the request edge.
    irq_in = 4'b0100;
    tick(); irq_in = '0;
    ticks(2); #1;
    chk("t1_sf1_early", sf1_d[0], 0);
    tick(); #1;
    chk("t1_sf1", sf1_d[0], 1);
    chk("t1_vec", vec_d[0], 2);
    chk("t1_int_clr", clr_d[0], 1);
    tick(); #1;
    chk("t1_int_en", en_d[0], 1);
    chk("t1_active_id", aid_d[0], 2);
    chk("t1_pending", pend_d[0], 0);
    chk("t1_sf1_after", sf1_d[0], 0);
    pulse_rti();
    chk("t1_int_en_rti", en_d[0], 0);

    // Simultaneous sources 3 and 1: 1 first, 3 after retire.
    irq_in = 4'b1010;
    tick(); irq_in = '0;
    ticks(3); #1;
    chk("t2_sf1_a", sf1_d[0], 1);
    chk("t2_vec_a", vec_d[0], 1);
    tick(); #1;
    chk("t2_active_a", aid_d[0], 1);
    chk("t2_pending_a", pend_d[0], 4'b1000);
    ticks(3); #1;
    chk("t2_no_inject", sf1_d[0], 0);
    rti_retire = 1'b1;
    tick(); rti_retire = 1'b0;
    ticks(3); #1;
    chk("t2_sf1_b", sf1_d[0], 1);
    chk("t2_vec_b", vec_d[0], 3);
    tick(); #1;
    chk("t2_active_b", aid_d[0], 3);
    pulse_rti();

    // Three stalls in DRAIN plus a branch at count 1: sf1 at cycle 9.
    irq_in = 4'b0001;
    tick(); irq_in = '0;
    tick(); stall_in = 1'b1;
    ticks(3); stall_in = 1'b0;
    tick(); branch_taken = 1'b1;
    tick(); branch_taken = 1'b0;
    tick(); #1;
    chk("t3_sf1_c8", sf1_d[0], 0);
    tick(); stall_in = 1'b1; #1;
    chk("t3_sf1_c9", sf1_d[0], 1);
    chk("t3_clr_stalled", clr_d[0], 0);
    tick(); #1;
    chk("t3_sf1_hold", sf1_d[0], 1);
    chk("t3_vec_hold", vec_d[0], 0);
    chk("t3_clr_hold", clr_d[0], 0);
    stall_in = 1'b0; #1;
    chk("t3_clr", clr_d[0], 1);
    tick(); #1;
    chk("t3_clr_once", clr_d[0], 0);
    chk("t3_sf1_done", sf1_d[0], 0);
    chk("t3_active", aid_d[0], 0);
    pulse_rti();

    // Masked source stays pending; unmasking injects DRAIN+1 cycles later.
    mask_wr = 1'b1; mask_in = 4'b1110;
    tick(); mask_wr = 1'b0; #1;
    chk("t4_mask", mask_d[0], 4'b1110);
    irq_in = 4'b0001;
    tick(); irq_in = '0;
    ticks(4); #1;
    chk("t4_pending", pend_d[0], 4'b0001);
    chk("t4_no_inject", sf1_d[0], 0);
    mask_wr = 1'b1; mask_in = 4'hf;
    tick(); mask_wr = 1'b0; #1;
    chk("t4_sf1_w0", sf1_d[0], 0);
    ticks(2); #1;
    chk("t4_sf1_w2", sf1_d[0], 0);
    tick(); #1;
    chk("t4_sf1_w3", sf1_d[0], 1);
    tick();
    pulse_rti();

    // Nesting: source 2 in service, source 0 arrives.
    irq_in = 4'b0100;
    tick(); irq_in = '0;
    ticks(4);
    irq_in = 4'b0001;
    tick(); irq_in = '0;
    ticks(3); #1;
    chk("t5_nest_sf1", sf1_d[1], 1);
    chk("t5_nest_vec", vec_d[1], 0);
    chk("t5_flat_sf1", sf1_d[0], 0);
    tick(); #1;
    chk("t5_nest_active", aid_d[1], 0);
    chk("t5_nest_en", en_d[1], 1);
    chk("t5_flat_active", aid_d[0], 2);
    pulse_rti();
    chk("t5_nest_active_r1", aid_d[1], 2);
    chk("t5_flat_en_r1", en_d[0], 0);
    ticks(2); #1;
    chk("t5_flat_sf1_early", sf1_d[0], 0);
    tick(); #1;
    chk("t5_flat_sf1", sf1_d[0], 1);
    chk("t5_flat_vec", vec_d[0], 0);
    tick(); #1;
    chk("t5_flat_active_0", aid_d[0], 0);
    pulse_rti();
    chk("t5_nest_en_r2", en_d[1], 0);
    chk("t5_flat_en_r2", en_d[0], 0);

    // Reset asserted while INJECT is held by a stall.
    irq_in = 4'b0010;
    tick(); irq_in = '0;
    ticks(3); stall_in = 1'b1; #1;
    chk("t6_sf1_before", sf1_d[0], 1);
    rst = 1'b0; #1;
    chk("t6_sf1_rst", sf1_d[0], 0);
    chk("t6_pending_rst", pend_d[0], 0);
    chk("t6_clr_rst", clr_d[0], 0);
    ticks(2); rst = 1'b1; stall_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_no_glitch", sf1_d[0] | sf1_d[1], 0);
      tick();
    end

    // Randomised traffic, model-checked every cycle.
    for (int n = 0; n < 1500; n++) begin
      irq_in       = irq_in ^ 4'($urandom & $urandom);
      mask_wr      = ($urandom_range(0, 15) == 0);
      mask_in      = 4'($urandom | $urandom);
      stall_in     = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      rti_retire   = ($urandom_range(0, 7) == 0);
      if (n == 700) rst = 1'b0;
      if (n == 702) rst = 1'b1;
      tick();
    end

    irq_in = '0; mask_wr = 1'b0; stall_in = 1'b0; branch_taken = 1'b0; rti_retire = 1'b0;
    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
